// File: rtl/serial_link_arbiter_if.sv
// Requester, Arduino and serial-link signals shared by the arbiter and its environment.
interface serial_link_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  // Instruction-fetch requester
  logic             fetch_req;
  logic [WIDTH-1:0] fetch_addr;
  logic             fetch_gnt;
  logic             fetch_done;
  logic [WIDTH-1:0] fetch_data;
  // Data-access requester
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_gnt;
  logic             mem_done;
  logic [WIDTH-1:0] mem_rdata;
  // Arduino link
  logic             ard_receive_ready;
  logic             ard_data_ready;
  logic             ser_in;
  logic             ser_out;
  logic             ser_out_valid;
  logic             busy;

  // Arbiter side
  modport slave (
    input  fetch_req, fetch_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  ard_receive_ready, ard_data_ready, ser_in,
    output fetch_gnt, fetch_done, fetch_data, mem_gnt, mem_done, mem_rdata,
    output ser_out, ser_out_valid, busy
  );

  // Requesters plus Arduino side
  modport master (
    output fetch_req, fetch_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output ard_receive_ready, ard_data_ready, ser_in,
    input  fetch_gnt, fetch_done, fetch_data, mem_gnt, mem_done, mem_rdata,
    input  ser_out, ser_out_valid, busy
  );
endinterface

// File: rtl/serial_link_arbiter.sv
// Arbitrates fetch and data requesters onto one bit-serial Arduino link and frames each
// transaction as command bit, address and optional write data, MSB first.
module serial_link_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  serial_link_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle, StWaitRr, StSendCmd, StSendAddr, StSendData, StWaitDr, StRecv, StDone
  } state_e;

  state_e           state_q, state_d;
  logic             owner_mem_q, owner_mem_d;  // 1 = data side owns the link
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; data side wins arbitration in idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (bus.mem_req || bus.fetch_req) state_d = StWaitRr;
      StWaitRr:   if (bus.ard_receive_ready) state_d = StSendCmd;
      StSendCmd:  state_d = StSendAddr;
      StSendAddr: if (cnt_q == '0) state_d = we_q ? StSendData : StWaitDr;
      StSendData: if (cnt_q == '0) state_d = StDone;
      StWaitDr:   if (bus.ard_data_ready) state_d = StRecv;
      StRecv:     if (cnt_q == '0) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath registers: latched request, bit counter, receive shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      sreg_q      <= '0;
    end else begin
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
    end
  end

  // Datapath next-state: requests are sampled only at grant
  always_comb begin
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_req) begin
          owner_mem_d = 1'b1;
          we_d        = bus.mem_we;
          addr_d      = bus.mem_addr;
          wdata_d     = bus.mem_wdata;
        end else if (bus.fetch_req) begin
          owner_mem_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = bus.fetch_addr;
          wdata_d     = '0;
        end
      end
      StSendCmd, StWaitDr: cnt_d = CntMax;
      StSendAddr, StSendData: cnt_d = (cnt_q == '0) ? CntMax : cnt_q - CntW'(1);
      StRecv: begin
        sreg_d = {sreg_q[WIDTH-2:0], bus.ser_in};
        cnt_d  = cnt_q - CntW'(1);
      end
      default: ;
    endcase
  end

  // Outputs decoded from state only; ser_out is forced low outside frame bits
  always_comb begin
    bus.ser_out       = 1'b0;
    bus.ser_out_valid = 1'b0;
    unique case (state_q)
      StSendCmd: begin
        bus.ser_out       = we_q;
        bus.ser_out_valid = 1'b1;
      end
      StSendAddr: begin
        bus.ser_out       = addr_q[cnt_q];
        bus.ser_out_valid = 1'b1;
      end
      StSendData: begin
        bus.ser_out       = wdata_q[cnt_q];
        bus.ser_out_valid = 1'b1;
      end
      default: ;
    endcase
    bus.busy       = (state_q != StIdle);
    bus.fetch_gnt  = (state_q != StIdle) && !owner_mem_q;
    bus.mem_gnt    = (state_q != StIdle) && owner_mem_q;
    bus.fetch_done = (state_q == StDone) && !owner_mem_q;
    bus.mem_done   = (state_q == StDone) && owner_mem_q;
    bus.fetch_data = sreg_q;
    bus.mem_rdata  = sreg_q;
  end
endmodule

// File: tb/tb_serial_link_arbiter.sv
// Bench for serial_link_arbiter: behavioural Arduino responder plus a transaction-level
// model of frame contents, done latency and returned data.
module tb_serial_link_arbiter;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_link_arbiter_if #(.WIDTH(WIDTH)) bus ();
  serial_link_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arduino model state
  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } frame_t;
  frame_t      frames_q[$];
  logic [15:0] resp_q[$];
  bit          bits_q[$];
  frame_t      ard_f;
  int          dr_wait = 1;
  bit          dr_noise = 0;
  int          dr_cd = 0;
  int          send_left = 0;
  logic [15:0] send_word;

  // Arduino: collects frame bits, answers loads after dr_wait cycles, MSB first
  initial forever begin
    @(negedge clk);
    if (rst) begin
      bits_q.delete();
      dr_cd = 0;
      send_left = 0;
      bus.ard_data_ready = 1'b0;
      bus.ser_in = 1'b0;
    end else begin
      bus.ard_data_ready = 1'b0;
      if (send_left > 0) begin
        bus.ser_in = send_word[send_left-1];
        send_left--;
      end else if (dr_cd > 0) begin
        dr_cd--;
        bus.ser_in = 1'($urandom);
        if (dr_cd == 0) begin
          bus.ard_data_ready = 1'b1;
          if (resp_q.size() > 0) send_word = resp_q.pop_front();
          else send_word = 16'hDEAD;
          send_left = 16;
        end
      end else begin
        bus.ser_in = 1'($urandom);
        if (dr_noise) bus.ard_data_ready = 1'($urandom);
      end
      if (bus.ser_out_valid) begin
        bits_q.push_back(bus.ser_out);
        if ((bits_q[0] && bits_q.size() == 33) || (!bits_q[0] && bits_q.size() == 17)) begin
          ard_f.we = bits_q[0];
          ard_f.addr = '0;
          ard_f.wdata = '0;
          for (int i = 1; i <= 16; i++) ard_f.addr = {ard_f.addr[14:0], bits_q[i]};
          if (ard_f.we) for (int i = 17; i <= 32; i++) ard_f.wdata = {ard_f.wdata[14:0], bits_q[i]};
          frames_q.push_back(ard_f);
          bits_q.delete();
          if (!ard_f.we) dr_cd = dr_wait;
        end
      end else begin
        check("ser_out_idle_zero", bus.ser_out, 1'b0);
      end
    end
  end

  int          last_gnt_cyc, last_done_cyc;
  logic [15:0] got_m_data;

  // One fetch and/or one data transaction started together; RR held low `stall` cycles after
  // the first grant. Expected done cycles come from the frame-length arithmetic.
  task automatic run_pair(input bit f_en, input logic [15:0] f_addr, input logic [15:0] f_resp,
                          input bit m_en, input bit m_we, input logic [15:0] m_addr,
                          input logic [15:0] m_wdata, input logic [15:0] m_resp,
                          input int wdr, input int stall);
    int exp_m, exp_f, n, g, m_done_n, f_done_n, first_valid_n, nf;
    bit bad_other, stall_ok, both_gnt;
    logic [15:0] f_data;
    frame_t fr;
    exp_m = m_en ? 36 + (m_we ? 0 : wdr) + stall : 0;
    exp_f = f_en ? exp_m + 36 + wdr + (m_en ? 0 : stall) : 0;
    if (m_en && !m_we) resp_q.push_back(m_resp);
    if (f_en) resp_q.push_back(f_resp);
    dr_wait = wdr;
    @(negedge clk);
    if (stall > 0) bus.ard_receive_ready = 1'b0;
    bus.fetch_req = f_en;
    bus.fetch_addr = f_addr;
    bus.mem_req = m_en;
    bus.mem_we = m_we;
    bus.mem_addr = m_addr;
    bus.mem_wdata = m_wdata;
    n = 1; g = 0; m_done_n = 0; f_done_n = 0; first_valid_n = 0;
    stall_ok = 1; both_gnt = 0; bad_other = 0; f_data = '0;
    while (n < 400 && !((!m_en || m_done_n > 0) && (!f_en || f_done_n > 0))) begin
      @(negedge clk);
      n++;
      if (g == 0 && (bus.fetch_gnt || bus.mem_gnt)) begin
        g = n;
        last_gnt_cyc = cyc;
      end
      if (bus.fetch_gnt && bus.mem_gnt) both_gnt = 1;
      if (stall > 0 && g > 0 && n <= g + stall && (bus.ser_out_valid || !bus.busy)) stall_ok = 0;
      if (stall > 0 && g > 0 && n == g + stall) bus.ard_receive_ready = 1'b1;
      if (first_valid_n == 0 && bus.ser_out_valid) first_valid_n = n;
      if (bus.mem_done) begin
        if (!m_en || m_done_n > 0 || !bus.mem_gnt) bad_other = 1;
        else begin
          m_done_n = n;
          got_m_data = bus.mem_rdata;
          bus.mem_req = 1'b0;
          last_done_cyc = cyc;
        end
      end
      if (bus.fetch_done) begin
        if (!f_en || f_done_n > 0 || !bus.fetch_gnt) bad_other = 1;
        else begin
          f_done_n = n;
          f_data = bus.fetch_data;
          bus.fetch_req = 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
    bus.fetch_req = 1'b0;
    bus.mem_req = 1'b0;
    bus.ard_receive_ready = 1'b1;
    if (m_en) begin
      check("mem_done_cycle", m_done_n, exp_m);
      if (!m_we) check("mem_rdata", got_m_data, m_resp);
    end
    if (f_en) begin
      check("fetch_done_cycle", f_done_n, exp_f);
      check("fetch_data", f_data, f_resp);
    end
    check("stray_done", bad_other, 1'b0);
    check("gnt_exclusive", both_gnt, 1'b0);
    check("grant_cycle", g, 2);
    if (stall > 0) begin
      check("stall_hold", stall_ok, 1'b1);
      check("frame_start", first_valid_n, g + stall + 1);
    end
    nf = m_en + f_en;
    check("frame_count", frames_q.size(), nf);
    if (m_en && frames_q.size() > 0) begin
      fr = frames_q.pop_front();
      check("mem_frame_cmd", fr.we, m_we);
      check("mem_frame_addr", fr.addr, m_addr);
      if (m_we) check("mem_frame_wdata", fr.wdata, m_wdata);
    end
    if (f_en && frames_q.size() > 0) begin
      fr = frames_q.pop_front();
      check("fetch_frame_cmd", fr.we, 1'b0);
      check("fetch_frame_addr", fr.addr, f_addr);
    end
    frames_q.delete();
    resp_q.delete();
  endtask

  initial begin
    int prev_done, n;
    bit saw_done;
    bit m_en, f_en;
    rst = 1'b1;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.ard_receive_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_gnt", {bus.fetch_gnt, bus.mem_gnt}, 2'b00);
    check("rst_done", {bus.fetch_done, bus.mem_done}, 2'b00);
    check("rst_ser", {bus.ser_out_valid, bus.ser_out}, 2'b00);
    check("rst_data", {bus.fetch_data, bus.mem_rdata}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch 0x1234, Arduino answers 0xBEEF after 3 idle WAIT_DR cycles
    run_pair(1, 16'h1234, 16'hBEEF, 0, 0, 16'h0, 16'h0, 16'h0, 4, 0);

    // Store with spurious data-ready pulses; read data must hold the previous load
    dr_noise = 1;
    run_pair(0, 16'h0, 16'h0, 1, 1, 16'h00A5, 16'hC3C3, 16'h0, 1, 0);
    dr_noise = 0;
    check("rdata_hold_after_store", got_m_data, 16'hBEEF);

    // Contention: data load wins, fetch follows
    run_pair(1, 16'h2222, 16'h4C4C, 1, 0, 16'h0010, 16'h0, 16'h7777, 2, 0);

    // Receive-ready stall for 20 cycles after grant
    run_pair(1, 16'hF00D, 16'h0BAD, 0, 0, 16'h0, 16'h0, 16'h0, 1, 20);

    // Reset after 8 received bits
    resp_q.push_back(16'h5A5A);
    dr_wait = 1;
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'h4321;
    n = 0;
    while (send_left != 8 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("recv_reached", send_left, 8);
    #2;
    rst = 1'b1;
    bus.fetch_req = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_gnt", {bus.fetch_gnt, bus.mem_gnt}, 2'b00);
    check("midrst_done", {bus.fetch_done, bus.mem_done}, 2'b00);
    check("midrst_ser", {bus.ser_out_valid, bus.ser_out}, 2'b00);
    check("midrst_data", {bus.fetch_data, bus.mem_rdata}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.fetch_done || bus.mem_done || bus.busy) saw_done = 1;
    end
    check("midrst_quiet", saw_done, 1'b0);
    frames_q.delete();
    resp_q.delete();
    run_pair(1, 16'h0777, 16'h1357, 0, 0, 16'h0, 16'h0, 16'h0, 2, 0);

    // Back-to-back fetches
    for (int i = 0; i < 4; i++) begin
      prev_done = last_done_cyc;
      run_pair(1, 16'(i), 16'(16'h1000 + i), 0, 0, 16'h0, 16'h0, 16'h0, 1, 0);
      if (i > 0) check("b2b_gap", last_gnt_cyc - prev_done, 2);
    end

    // Random mix
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(2, 0))
        0: begin f_en = 1; m_en = 0; end
        1: begin f_en = 0; m_en = 1; end
        default: begin f_en = 1; m_en = 1; end
      endcase
      run_pair(f_en, 16'($urandom), 16'($urandom), m_en, 1'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), int'($urandom_range(5, 1)),
               int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_link_arbiter.md
# serial_link_arbiter

Shares the single bit-serial link to the Arduino memory model between the CPU's two memory requesters: instruction fetch (PC out, instruction in) and data access (MAR out, MDR in/out for loads and stores). It arbitrates, frames each transaction as command bit + address + optional data, counts bits, and handshakes with the Arduino ready lines. It returns one done pulse per transaction, with read data, to the winning requester.

## Interface
- WIDTH, 16, address and data word width; bit counter is $clog2(WIDTH) bits.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  fetch request; held until fetch_done.
- fetch_addr  in  WIDTH  PC value to fetch from.
- fetch_gnt  out  1  fetch owns the link, from grant through done.
- fetch_done  out  1  one-cycle pulse; fetch_data valid.
- fetch_data  out  WIDTH  received instruction word.
- mem_req  in  1  data request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  WIDTH  MAR value.
- mem_wdata  in  WIDTH  MDR value for stores.
- mem_gnt  out  1  data side owns the link, from grant through done.
- mem_done  out  1  one-cycle pulse; load or store complete.
- mem_rdata  out  WIDTH  received load word (don't-care after store).
- ard_receive_ready  in  1  Arduino can accept a frame.
- ard_data_ready  in  1  Arduino begins sending read data next cycle.
- ser_in  in  1  serial data from Arduino, MSB first.
- ser_out  out  1  serial data to Arduino, MSB first.
- ser_out_valid  out  1  ser_out carries a frame bit this cycle.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT_RR, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_DR, RECV, DONE.
- IDLE: if mem_req, grant data side; else if fetch_req, grant fetch. Data has fixed priority. On grant, latch owner, we (forced 0 for fetch), addr and wdata; go to WAIT_RR.
- WAIT_RR: hold until ard_receive_ready = 1, then SEND_CMD.
- SEND_CMD: 1 cycle; ser_out = latched we, ser_out_valid = 1; load bit counter with WIDTH-1; go to SEND_ADDR.
- SEND_ADDR: ser_out = addr[cnt], ser_out_valid = 1, cnt decrements. At cnt = 0, reload WIDTH-1, then go to SEND_DATA if we, else WAIT_DR.
- SEND_DATA: ser_out = wdata[cnt], same counting; at cnt = 0 go to DONE.
- WAIT_DR: hold until ard_data_ready = 1; then RECV with cnt = WIDTH-1.
- RECV: each cycle, shift register <= {sreg[WIDTH-2:0], ser_in}; at cnt = 0 go to DONE.
- DONE: 1 cycle; owner's done = 1; then IDLE. No arbitration in DONE.
- fetch_data and mem_rdata are both driven by the shift register. The value holds from DONE until the next RECV begins.
- Request inputs are sampled only at grant. Dropping req mid-transaction does not abort it.
- Requesters deassert req at the edge that ends their done cycle, so IDLE never re-grants a stale request.
- ser_out = 0 whenever ser_out_valid = 0.

## Timing
- Reset: state IDLE, counter 0, shift register 0, all outputs 0. Asynchronous assertion; the first transition occurs on the first edge after deassertion.
- Reset mid-transaction: link goes idle immediately and ser_out_valid drops. No done pulse. Latched request is discarded.
- Grant occurs on the edge after req is seen in IDLE; gnt is high from WAIT_RR through DONE.
- With ard_receive_ready already high, a store takes 1 (IDLE) + 1 (WAIT_RR) + 1 + 16 + 16 + 1 (DONE) = 36 cycles from req to done cycle, inclusive.
- A load or fetch takes 1 + 1 + 1 + 16 + W + 16 + 1 cycles, where W ≥ 1 is the number of WAIT_DR cycles.
- ard_data_ready is sampled only in WAIT_DR. Assertions in other states are ignored.
- Simultaneous fetch_req and mem_req: data wins. Fetch is granted on the IDLE cycle after mem_done, provided mem_req has dropped.
- Back-to-back requests: at most one IDLE cycle between DONE and the next grant.

## Test plan
- Fetch: fetch_addr = 0x1234, RR high, DR after 3 cycles, Arduino sends 0xBEEF. Expect ser_out bits 0 then 0x1234 MSB first, fetch_done pulse, fetch_data = 0xBEEF, mem_done never high.
- Store: mem_we = 1, mem_addr = 0x00A5, mem_wdata = 0xC3C3. Expect 33 valid serial bits: 1, 0x00A5, 0xC3C3; mem_done on cycle 36; ard_data_ready ignored.
- Contention: fetch_req and mem_req (load, addr 0x0010, data 0x7777) rise together. Expect mem_gnt first and mem_rdata = 0x7777, then fetch granted and completed.
- Stall: ard_receive_ready low for 20 cycles after grant. Expect WAIT_RR held, ser_out_valid = 0, busy = 1; the frame starts on the cycle after RR rises.
- Reset mid-RECV: assert rst after 8 received bits. Expect all outputs 0 at once, no done pulse, and a clean fetch afterwards.
- Back-to-back: 4 fetches at 0x0000..0x0003 returning 0x1000..0x1003. Expect in-order data with at most one idle cycle between frames.
